// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: register map, CTRL/STATUS bit positions and TX scheduler states for uart_seq.
package uart_seq_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLR    = 2'd3;
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_IRQ_RX  = 2;
  localparam int CTRL_IRQ_TXE = 3;
  localparam int CTRL_BAUD    = 4;
  localparam int ST_RXF_EMPTY = 0;
  localparam int ST_RXF_FULL  = 1;
  localparam int ST_TXF_EMPTY = 2;
  localparam int ST_TXF_FULL  = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_OVR       = 5;
  localparam int BUS_W        = 16;
  typedef enum logic [1:0] {IDLE, POP, LOAD, WAIT} tx_state_e;
endpackage

// File: rtl/uart_seq_if.sv
// uart_seq_if: core-bus register access port; names are as seen from the sequencer.
interface uart_seq_if;
  logic        wr_en_i;
  logic        rd_en_i;
  logic [1:0]  addr_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  modport master (output wr_en_i, rd_en_i, addr_i, data_i, input data_o);
  modport slave  (input wr_en_i, rd_en_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/uart_seq_tx_sched.sv
// uart_tx_sched: pops one byte from the TX fifo and hands it to uart_tx, one frame at a time.
module uart_tx_sched
  import uart_seq_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_en_i,
  input  logic                 txf_empty_i,
  input  logic [DataWidth-1:0] txf_rd_data_i,
  input  logic                 tx_busy_i,
  output logic                 txf_rd_en_o,
  output logic                 tx_dv_o,
  output logic [DataWidth-1:0] tx_data_o,
  output logic                 tx_idle_o
);
  tx_state_e state_q;
  logic      busy_q;
  // The pop is issued on the IDLE->POP transition so the fifo head is valid while in POP.
  assign txf_rd_en_o = (state_q == IDLE) && tx_en_i && !txf_empty_i && !tx_busy_i;
  assign tx_idle_o   = (state_q == IDLE);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tx_dv_o   <= 1'b0;
      tx_data_o <= '0;
      busy_q    <= 1'b0;
    end else begin
      busy_q  <= tx_busy_i;
      tx_dv_o <= 1'b0;
      case (state_q)
        IDLE: if (txf_rd_en_o) state_q <= POP;
        POP: begin
          state_q   <= LOAD;
          tx_data_o <= txf_rd_data_i;
          tx_dv_o   <= 1'b1;
        end
        LOAD: state_q <= WAIT;
        WAIT: if (busy_q && !tx_busy_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_seq.sv
// uart_seq: register-mapped sequencer between the core bus and the UART fifos/datapath.
module uart_seq
  import uart_seq_pkg::*;
#(
  parameter int DataWidth    = 8,
  parameter int BaudSelWidth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  uart_seq_if.slave               bus,
  output logic                    txf_wr_en_o,
  output logic [DataWidth-1:0]    txf_wr_data_o,
  input  logic                    txf_full_i,
  output logic                    txf_rd_en_o,
  input  logic [DataWidth-1:0]    txf_rd_data_i,
  input  logic                    txf_empty_i,
  output logic                    tx_dv_o,
  output logic [DataWidth-1:0]    tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    rx_dv_i,
  input  logic [DataWidth-1:0]    rx_data_i,
  output logic                    rxf_wr_en_o,
  output logic [DataWidth-1:0]    rxf_wr_data_o,
  input  logic                    rxf_full_i,
  output logic                    rxf_rd_en_o,
  input  logic [DataWidth-1:0]    rxf_rd_data_i,
  input  logic                    rxf_empty_i,
  output logic [BaudSelWidth-1:0] baud_sel_o,
  output logic                    irq_o
);
  localparam int CtrlW = 4 + BaudSelWidth;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic             ovr_q, ovr_d, irq_q, irq_d, pop_q, tx_idle;
  logic             wr_data, rd_data, wr_ctrl, ovr_set, ovr_clr;
  logic [BUS_W-1:0] rdata_q, rdata_d, status;
  logic             unused_data;
  assign unused_data   = ^bus.data_i[BUS_W-1:DataWidth];
  assign wr_data       = bus.wr_en_i && (bus.addr_i == ADDR_DATA);
  assign rd_data       = bus.rd_en_i && (bus.addr_i == ADDR_DATA);
  assign wr_ctrl       = bus.wr_en_i && (bus.addr_i == ADDR_CTRL);
  assign txf_wr_en_o   = wr_data && !txf_full_i;
  assign txf_wr_data_o = bus.data_i[DataWidth-1:0];
  assign rxf_rd_en_o   = rd_data && !rxf_empty_i;
  assign rxf_wr_en_o   = rx_dv_i && ctrl_q[CTRL_RX_EN] && !rxf_full_i;
  assign rxf_wr_data_o = rx_data_i;
  assign ovr_set       = rx_dv_i && ctrl_q[CTRL_RX_EN] && rxf_full_i;
  assign ovr_clr       = bus.wr_en_i && (bus.addr_i == ADDR_CLR) && bus.data_i[0];
  assign baud_sel_o    = ctrl_q[CTRL_BAUD +: BaudSelWidth];
  assign irq_o         = irq_q;
  // The fifo head only becomes valid the cycle after the pop, so DATA reads bypass the read register.
  assign bus.data_o    = pop_q ? BUS_W'(rxf_rd_data_i) : rdata_q;
  always_comb begin
    status               = '0;
    status[ST_RXF_EMPTY] = rxf_empty_i;
    status[ST_RXF_FULL]  = rxf_full_i;
    status[ST_TXF_EMPTY] = txf_empty_i;
    status[ST_TXF_FULL]  = txf_full_i;
    status[ST_TX_BUSY]   = tx_busy_i;
    status[ST_OVR]       = ovr_q;
    rdata_d = (bus.addr_i == ADDR_STATUS) ? status :
              (bus.addr_i == ADDR_CTRL)   ? BUS_W'(ctrl_q) : '0;
    ctrl_d  = wr_ctrl ? bus.data_i[CtrlW-1:0] : ctrl_q;
    ovr_d   = ovr_set ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
    irq_d   = (ctrl_q[CTRL_IRQ_RX] && !rxf_empty_i) ||
              (ctrl_q[CTRL_IRQ_TXE] && txf_empty_i && tx_idle) || ovr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      pop_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      ovr_q  <= ovr_d;
      irq_q  <= irq_d;
      pop_q  <= rxf_rd_en_o;
      if (bus.rd_en_i) rdata_q <= rdata_d;
    end
  end
  uart_tx_sched #(.DataWidth(DataWidth)) u_tx_sched (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tx_en_i       (ctrl_q[CTRL_TX_EN]),
    .txf_empty_i   (txf_empty_i),
    .txf_rd_data_i (txf_rd_data_i),
    .tx_busy_i     (tx_busy_i),
    .txf_rd_en_o   (txf_rd_en_o),
    .tx_dv_o       (tx_dv_o),
    .tx_data_o     (tx_data_o),
    .tx_idle_o     (tx_idle)
  );
endmodule

// File: tb/tb_uart_seq.sv
// tb_uart_seq: directed bench for uart_seq with fifo/uart_tx models and scoreboard queues.
module tb_uart_seq;
  import uart_seq_pkg::*;
  localparam int RXD = 2;
  localparam int TXD = 4;
  localparam int BUSY_CYC = 10;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       txf_wr_en, txf_rd_en, tx_dv, rxf_wr_en, rxf_rd_en, irq_o;
  logic [7:0] txf_wr_data, tx_data, rxf_wr_data;
  logic [1:0] baud_sel;
  logic       txf_empty = 1'b1, txf_full = 1'b0, rxf_empty = 1'b1, rxf_full = 1'b0, tx_busy = 1'b0;
  logic [7:0] txf_rd_data = '0, rxf_rd_data = '0, tx_tmp, rx_tmp;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_data = '0;
  logic       prev_dv = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] txq[$], rxq[$], exp_tx[$], exp_txw[$], exp_rxw[$];
  int         cmp_n = 0, err_n = 0, tx_frames = 0, txf_pops = 0, f0, p0;
  uart_seq_if bus();
  uart_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
    .txf_wr_en_o(txf_wr_en), .txf_wr_data_o(txf_wr_data), .txf_full_i(txf_full),
    .txf_rd_en_o(txf_rd_en), .txf_rd_data_i(txf_rd_data), .txf_empty_i(txf_empty),
    .tx_dv_o(tx_dv), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .rx_dv_i(rx_dv), .rx_data_i(rx_data),
    .rxf_wr_en_o(rxf_wr_en), .rxf_wr_data_o(rxf_wr_data), .rxf_full_i(rxf_full),
    .rxf_rd_en_o(rxf_rd_en), .rxf_rd_data_i(rxf_rd_data), .rxf_empty_i(rxf_empty),
    .baud_sel_o(baud_sel), .irq_o(irq_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    cmp_n++;
    assert (got === exp) else begin
      err_n++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // Fifo models: registered head, flags updated after the push/pop of this edge.
  always @(posedge clk_i) begin
    if (txf_rd_en && txq.size() > 0) begin
      tx_tmp = txq.pop_front();
      txf_rd_data <= tx_tmp;
    end
    if (txf_wr_en && txq.size() < TXD) txq.push_back(txf_wr_data);
    txf_empty <= (txq.size() == 0);
    txf_full  <= (txq.size() == TXD);
  end
  always @(posedge clk_i) begin
    if (rxf_rd_en && rxq.size() > 0) begin
      rx_tmp = rxq.pop_front();
      rxf_rd_data <= rx_tmp;
    end
    if (rxf_wr_en && rxq.size() < RXD) rxq.push_back(rxf_wr_data);
    rxf_empty <= (rxq.size() == 0);
    rxf_full  <= (rxq.size() == RXD);
  end
  always @(posedge clk_i) begin
    if (tx_dv) begin
      tx_busy  <= 1'b1;
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end
  always @(posedge clk_i) begin
    #1;
    if (tx_dv) begin
      check("tx_dv_while_busy", 16'(tx_busy), 16'd0);
      check("tx_dv_width", 16'(prev_dv), 16'd0);
      check("tx_dv_expected", 16'(exp_tx.size() > 0), 16'd1);
      if (exp_tx.size() > 0) check("tx_data", 16'(tx_data), 16'(exp_tx.pop_front()));
      tx_frames++;
    end
    prev_dv = tx_dv;
  end
  always @(negedge clk_i) begin
    #3;
    if (txf_rd_en) txf_pops++;
    if (txf_wr_en) begin
      check("txf_push_expected", 16'(exp_txw.size() > 0), 16'd1);
      if (exp_txw.size() > 0) check("txf_wr_data", 16'(txf_wr_data), 16'(exp_txw.pop_front()));
    end
    if (rxf_wr_en) begin
      check("rxf_push_expected", 16'(exp_rxw.size() > 0), 16'd1);
      if (exp_rxw.size() > 0) check("rxf_wr_data", 16'(rxf_wr_data), 16'(exp_rxw.pop_front()));
    end
  end
  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_i);
    bus.wr_en_i = 1'b1;
    bus.addr_i  = a;
    bus.data_i  = d;
    @(negedge clk_i);
    bus.wr_en_i = 1'b0;
  endtask
  task automatic bus_rd(input logic [1:0] a, input logic [15:0] exp, input logic exp_pop, input string tag);
    logic pop;
    @(negedge clk_i);
    bus.rd_en_i = 1'b1;
    bus.addr_i  = a;
    #1 pop = rxf_rd_en;
    @(negedge clk_i);
    bus.rd_en_i = 1'b0;
    check({tag, "_data"}, bus.data_o, exp);
    check({tag, "_pop"}, 16'(pop), 16'(exp_pop));
  endtask
  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_dv   = 1'b1;
    rx_data = b;
    @(negedge clk_i);
    rx_dv   = 1'b0;
  endtask
  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && tx_frames < n; i++) @(negedge clk_i);
    check("frame_count", 16'(tx_frames), 16'(n));
  endtask
  initial begin
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.addr_i  = '0;
    bus.data_i  = '0;
    repeat (3) @(negedge clk_i);
    check("rst_data_o", bus.data_o, 16'h0000);
    check("rst_irq", 16'(irq_o), 16'd0);
    check("rst_tx_dv", 16'(tx_dv), 16'd0);
    check("rst_baud", 16'(baud_sel), 16'd0);
    rst_ni = 1'b1;
    bus_rd(ADDR_CTRL, 16'h0000, 1'b0, "ctrl_reset");
    bus_rd(ADDR_STATUS, 16'h0005, 1'b0, "status_reset");
    bus_wr(ADDR_CTRL, 16'hFF21);
    bus_rd(ADDR_CTRL, 16'h0021, 1'b0, "ctrl_rw");
    check("baud_sel", 16'(baud_sel), 16'd2);
    exp_txw.push_back(8'h55); exp_tx.push_back(8'h55);
    bus_wr(ADDR_DATA, 16'h1255);
    exp_txw.push_back(8'hA3); exp_tx.push_back(8'hA3);
    bus_wr(ADDR_DATA, 16'h00A3);
    wait_frames(2, 200);
    repeat (15) @(negedge clk_i);
    bus_rd(ADDR_STATUS, 16'h0005, 1'b0, "status_tx_done");
    bus_wr(ADDR_CTRL, 16'h0023);
    exp_rxw.push_back(8'h3C);
    rx_byte(8'h3C);
    bus_rd(ADDR_DATA, 16'h003C, 1'b1, "rx_read");
    exp_rxw.push_back(8'h11); rx_byte(8'h11);
    exp_rxw.push_back(8'h22); rx_byte(8'h22);
    bus_rd(ADDR_STATUS, 16'h0006, 1'b0, "status_rx_full");
    rx_byte(8'h99);
    bus_rd(ADDR_STATUS, 16'h0026, 1'b0, "status_ovr");
    @(negedge clk_i);
    check("irq_ovr", 16'(irq_o), 16'd1);
    bus_wr(ADDR_CLR, 16'h0001);
    @(negedge clk_i);
    check("irq_after_clr", 16'(irq_o), 16'd0);
    bus_rd(ADDR_STATUS, 16'h0006, 1'b0, "status_clr");
    @(negedge clk_i);
    bus.wr_en_i = 1'b1; bus.addr_i = ADDR_CLR; bus.data_i = 16'h0001;
    rx_dv = 1'b1; rx_data = 8'h77;
    @(negedge clk_i);
    bus.wr_en_i = 1'b0; rx_dv = 1'b0;
    bus_rd(ADDR_STATUS, 16'h0026, 1'b0, "status_set_wins");
    bus_wr(ADDR_CLR, 16'h0001);
    bus_rd(ADDR_DATA, 16'h0011, 1'b1, "rx_drain0");
    bus_rd(ADDR_DATA, 16'h0022, 1'b1, "rx_drain1");
    bus_rd(ADDR_DATA, 16'h0000, 1'b0, "rx_empty_read");
    bus_rd(ADDR_STATUS, 16'h0005, 1'b0, "status_drained");
    bus_wr(ADDR_CTRL, 16'h0027);
    exp_rxw.push_back(8'h5A);
    rx_byte(8'h5A);
    repeat (2) @(negedge clk_i);
    check("irq_rx", 16'(irq_o), 16'd1);
    bus_rd(ADDR_DATA, 16'h005A, 1'b1, "rx_irq_read");
    repeat (2) @(negedge clk_i);
    check("irq_rx_cleared", 16'(irq_o), 16'd0);
    bus_wr(ADDR_CTRL, 16'h002B);
    repeat (2) @(negedge clk_i);
    check("irq_txe", 16'(irq_o), 16'd1);
    bus_wr(ADDR_CTRL, 16'h0023);
    repeat (2) @(negedge clk_i);
    check("irq_txe_off", 16'(irq_o), 16'd0);
    f0 = tx_frames;
    p0 = txf_pops;
    exp_tx.push_back(8'h01);
    exp_txw.push_back(8'h01); bus_wr(ADDR_DATA, 16'h0001);
    exp_txw.push_back(8'h02); bus_wr(ADDR_DATA, 16'h0002);
    exp_txw.push_back(8'h03); bus_wr(ADDR_DATA, 16'h0003);
    bus_wr(ADDR_CTRL, 16'h0022);
    wait_frames(f0 + 1, 100);
    repeat (40) @(negedge clk_i);
    check("midframe_frames", 16'(tx_frames - f0), 16'd1);
    check("midframe_pops", 16'(txf_pops - p0), 16'd1);
    check("midframe_remain", 16'(txq.size()), 16'd2);
    bus_rd(ADDR_STATUS, 16'h0001, 1'b0, "status_midframe");
    exp_tx.push_back(8'h02);
    bus_wr(ADDR_CTRL, 16'h0023);
    for (int i = 0; i < 50 && !tx_dv; i++) begin
      @(posedge clk_i);
      #1;
    end
    check("dv_before_reset", 16'(tx_dv), 16'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("reset_drops_dv", 16'(tx_dv), 16'd0);
    check("reset_baud", 16'(baud_sel), 16'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus_rd(ADDR_CTRL, 16'h0000, 1'b0, "ctrl_after_reset");
    check("exp_tx_left", 16'(exp_tx.size()), 16'd0);
    check("exp_txw_left", 16'(exp_txw.size()), 16'd0);
    check("exp_rxw_left", 16'(exp_rxw.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
